// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot-time instruction loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        RUN   = 3'd4,
        ERROR = 3'd5
    } state_e;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
    localparam int          BYTE_CNT_W = 2;

    function automatic logic is_loading(input state_e s);
        return (s == HDR0) || (s == HDR1) || (s == DATA);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - valid/ready byte stream carrying the program image
interface instruction_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/instr_mem_array.sv
// rtl/instr_mem_array.sv - DEPTH x 32 instruction store, sync write, async read
module instr_mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Contents survive reset on purpose; visibility is gated by the loader's word count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream boot loader and instruction memory feeding the fetch stage
module instruction_loader
    import loader_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int IDX_W    = 8,
    parameter int PC_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_start,
    instruction_loader_if.slave  rx,
    input  logic [31:0]          pc,
    output logic [31:0]          instruction,
    output logic                 cpu_reset,
    output logic [15:0]          loaded_words,
    output logic                 load_error,
    output logic                 busy
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]             word_idx_q, word_idx_d;
    logic [23:0]             asm_q, asm_d;
    logic [15:0]             loaded_words_q, loaded_words_d;
    logic                    load_error_q, load_error_d;
    logic                    cpu_reset_q, cpu_reset_d;

    logic        xfer;
    logic        mem_we;
    logic [15:0] hdr_len;
    logic [15:0] word_next;
    logic [31:0] pc_word;
    logic [15:0] rd_idx;
    logic [31:0] mem_rdata;
    logic        unused_pc_hi;

    assign rx.rx_ready = is_loading(state_q);
    assign xfer        = rx.rx_valid && rx.rx_ready;
    assign hdr_len     = {rx.rx_data, len_q[7:0]};
    assign word_next   = word_idx_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_cnt_d     = byte_cnt_q;
        word_idx_d     = word_idx_q;
        asm_d          = asm_q;
        loaded_words_d = loaded_words_q;
        load_error_d   = load_error_q;
        mem_we         = 1'b0;

        // A restart outranks any byte arriving on the same edge; that byte is dropped.
        if (load_start) begin
            state_d        = HDR0;
            loaded_words_d = 16'd0;
            load_error_d   = 1'b0;
            byte_cnt_d     = '0;
        end else begin
            case (state_q)
                HDR0: begin
                    if (xfer) begin
                        len_d   = {8'd0, rx.rx_data};
                        state_d = HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        len_d = hdr_len;
                        if (hdr_len == 16'd0) begin
                            state_d = RUN;
                        end else if ({1'b0, hdr_len} > DEPTH_W) begin
                            state_d      = ERROR;
                            load_error_d = 1'b1;
                        end else begin
                            state_d    = DATA;
                            byte_cnt_d = '0;
                            word_idx_d = 16'd0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                        case (byte_cnt_q)
                            2'd0: asm_d[7:0]   = rx.rx_data;
                            2'd1: asm_d[15:8]  = rx.rx_data;
                            2'd2: asm_d[23:16] = rx.rx_data;
                            default: begin
                                mem_we         = 1'b1;
                                loaded_words_d = word_next;
                                word_idx_d     = word_next;
                                if (word_next == len_q) begin
                                    state_d = RUN;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end

        // Release trails entry into RUN by one edge; a restart raises it on the same edge.
        cpu_reset_d = (state_q != RUN) || load_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= 16'd0;
            byte_cnt_q     <= '0;
            word_idx_q     <= 16'd0;
            asm_q          <= 24'd0;
            loaded_words_q <= 16'd0;
            load_error_q   <= 1'b0;
            cpu_reset_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_cnt_q     <= byte_cnt_d;
            word_idx_q     <= word_idx_d;
            asm_q          <= asm_d;
            loaded_words_q <= loaded_words_d;
            load_error_q   <= load_error_d;
            cpu_reset_q    <= cpu_reset_d;
        end
    end

    instr_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx_q[IDX_W-1:0]),
        .wdata ({rx.rx_data, asm_q}),
        .raddr (rd_idx[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    assign pc_word      = pc >> PC_SHIFT;
    assign rd_idx       = pc_word[15:0];
    assign unused_pc_hi = ^pc_word[31:16];

    always_comb begin
        instruction = mem_rdata;
        if (cpu_reset_q || (rd_idx >= loaded_words_q) || ({1'b0, rd_idx} >= DEPTH_W)) begin
            instruction = NOP_INSN;
        end
    end

    assign cpu_reset    = cpu_reset_q;
    assign loaded_words = loaded_words_q;
    assign load_error   = load_error_q;
    assign busy         = is_loading(state_q);

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_reset;
    logic [15:0] loaded_words;
    logic        load_error;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    instruction_loader_if rx_if ();

    instruction_loader #(.DEPTH(256), .IDX_W(8), .PC_SHIFT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .rx           (rx_if),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_reset    (cpu_reset),
        .loaded_words (loaded_words),
        .load_error   (load_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        while (!rx_if.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_if.rx_ready) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout rx_ready got %b exp 1", rx_if.rx_ready);
        end
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    function automatic logic [31:0] fd_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {8'hA5, b, 8'h5A, ~b};
    endfunction

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0; pc = 32'd0;
        rx_if.rx_valid = 1'b0; rx_if.rx_data = 8'h00;
        @(negedge clk); @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", rx_if.rx_ready); end
        checks++; if (loaded_words !== 16'd0) begin errors++; $display("FAIL reset_loaded got %0d exp 0", loaded_words); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error got %b exp 0", load_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_insn got %h exp %h", instruction, NOP); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic_load();
        pulse_load();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h0000_10B7);
        checks++; if (loaded_words !== 16'd1) begin errors++; $display("FAIL basic_loaded1 got %0d exp 1", loaded_words); end
        send_word(32'h0020_8113);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_cpu_reset_lag got %b exp 1", cpu_reset); end
        checks++; if (loaded_words !== 16'd2) begin errors++; $display("FAIL basic_loaded got %0d exp 2", loaded_words); end
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_release got %b exp 0", cpu_reset); end
        checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL basic_rx_ready got %b exp 0", rx_if.rx_ready); end
        pc = 32'd0; #1;
        checks++; if (instruction !== 32'h0000_10B7) begin errors++; $display("FAIL basic_pc0 got %h exp 000010b7", instruction); end
        pc = 32'd4; #1;
        checks++; if (instruction !== 32'h0020_8113) begin errors++; $display("FAIL basic_pc4 got %h exp 00208113", instruction); end
        pc = 32'd7; #1;
        checks++; if (instruction !== 32'h0020_8113) begin errors++; $display("FAIL basic_pc7 got %h exp 00208113", instruction); end
        pc = 32'd8; #1;
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL basic_pc8 got %h exp %h", instruction, NOP); end
    endtask

    task automatic test_zero_length();
        pulse_load();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (loaded_words !== 16'd0) begin errors++; $display("FAIL reload_loaded got %0d exp 0", loaded_words); end
        send_byte(8'h00); send_byte(8'h00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy); end
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL zero_cpu_reset got %b exp 0", cpu_reset); end
        pc = 32'd0; #1;
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL zero_pc0 got %h exp %h", instruction, NOP); end
        pc = 32'd4; #1;
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL zero_pc4 got %h exp %h", instruction, NOP); end
    endtask

    task automatic test_oversize();
        pulse_load();
        send_byte(8'h01); send_byte(8'h01);
        @(negedge clk);
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL over_error got %b exp 1", load_error); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL over_cpu_reset got %b exp 1", cpu_reset); end
        checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL over_rx_ready got %b exp 0", rx_if.rx_ready); end
        pulse_load();
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL over_clear got %b exp 0", load_error); end
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL over_reload_run got %b exp 0", cpu_reset); end
        pc = 32'd0; #1;
        checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL over_reload_pc0 got %h exp deadbeef", instruction); end
    endtask

    task automatic test_backpressure();
        logic [7:0] img [14];
        img = '{8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77,
                8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
        pulse_load();
        for (int i = 0; i < 14; i++) begin
            for (int g = 0; g < (i % 3); g++) begin
                @(negedge clk);
                if (busy !== 1'b1) begin
                    checks++; errors++;
                    $display("FAIL bp_busy_gap got %b exp 1 at byte %0d", busy, i);
                end
            end
            send_byte(img[i]);
            if (i == 7) begin
                repeat (5) @(negedge clk);
                checks++; if (loaded_words !== 16'd1) begin errors++; $display("FAIL bp_stall_loaded got %0d exp 1", loaded_words); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_stall_busy got %b exp 1", busy); end
            end
        end
        checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL bp_rx_ready got %b exp 0", rx_if.rx_ready); end
        checks++; if (loaded_words !== 16'd3) begin errors++; $display("FAIL bp_loaded got %0d exp 3", loaded_words); end
        @(negedge clk);
        pc = 32'd0; #1;
        checks++; if (instruction !== 32'h1122_3344) begin errors++; $display("FAIL bp_pc0 got %h exp 11223344", instruction); end
        pc = 32'd4; #1;
        checks++; if (instruction !== 32'h5566_7788) begin errors++; $display("FAIL bp_pc4 got %h exp 55667788", instruction); end
        pc = 32'd8; #1;
        checks++; if (instruction !== 32'h99AA_BBCC) begin errors++; $display("FAIL bp_pc8 got %h exp 99aabbcc", instruction); end
    endtask

    task automatic test_abort();
        pulse_load();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h0403_0201);
        send_byte(8'h05); send_byte(8'h06);
        rx_if.rx_data = 8'h07; rx_if.rx_valid = 1'b1; load_start = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0; load_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", busy); end
        checks++; if (loaded_words !== 16'd0) begin errors++; $display("FAIL abort_loaded got %0d exp 0", loaded_words); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL abort_cpu_reset got %b exp 1", cpu_reset); end
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h1234_5678);
        @(negedge clk);
        checks++; if (loaded_words !== 16'd1) begin errors++; $display("FAIL abort_reload got %0d exp 1", loaded_words); end
        pc = 32'd0; #1;
        checks++; if (instruction !== 32'h1234_5678) begin errors++; $display("FAIL abort_pc0 got %h exp 12345678", instruction); end
        pc = 32'd4; #1;
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL abort_pc4 got %h exp %h", instruction, NOP); end
    endtask

    task automatic test_full_depth();
        pulse_load();
        send_byte(8'h00); send_byte(8'h01);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_accept_busy got %b exp 1", busy); end
        for (int i = 0; i < 256; i++) send_word(fd_word(i));
        checks++; if (loaded_words !== 16'd256) begin errors++; $display("FAIL full_loaded got %0d exp 256", loaded_words); end
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL full_run got %b exp 0", cpu_reset); end
        pc = 32'd1020; #1;
        checks++; if (instruction !== fd_word(255)) begin errors++; $display("FAIL full_last got %h exp %h", instruction, fd_word(255)); end
        pc = 32'd1024; #1;
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL full_past got %h exp %h", instruction, NOP); end
        pc = 32'h0004_0004; #1;
        checks++; if (instruction !== fd_word(1)) begin errors++; $display("FAIL full_trunc got %h exp %h", instruction, fd_word(1)); end
    endtask

    task automatic test_reload_reset();
        pulse_load();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rr_cpu_reset got %b exp 1", cpu_reset); end
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hCAFE_F00D);
        send_byte(8'hAB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pc = 32'd0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rr_cpu_reset_idle got %b exp 1", cpu_reset); end
        checks++; if (loaded_words !== 16'd0) begin errors++; $display("FAIL rr_loaded got %0d exp 0", loaded_words); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL rr_insn got %h exp %h", instruction, NOP); end
        @(negedge clk);
        checks++; if (rx_if.rx_ready !== 1'b0) begin errors++; $display("FAIL rr_rx_ready got %b exp 0", rx_if.rx_ready); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_length();
        test_oversize();
        test_backpressure();
        test_abort();
        test_full_depth();
        test_reload_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Upstream feeder of the 5-stage processor's fetch stage. Owns the instruction memory and a byte-stream boot loader.
- Holds the core in reset while a program image arrives over a valid/ready byte interface.
- Assembles little-endian 32-bit words, writes them into the memory, then releases the core.
- In run mode, returns the instruction at the core's pc combinationally; the fetch stage registers it into ir2.

Parameters:
- DEPTH, 256: instruction words stored; must be ≤ 65535.
- IDX_W, 8: word-index width, equal to clog2(DEPTH).
- PC_SHIFT, 2: right shift converting the byte-address pc to a word index.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle pulse; begins or restarts an image load.
- rx_data  input  8  image byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready at a clk edge.
- pc  input  32  fetch address from the core.
- instruction  output  32  instruction word at pc.
- cpu_reset  output  1  drives the core's reset; registered.
- loaded_words  output  16  count of valid words written.
- load_error  output  1  image length exceeds DEPTH.
- busy  output  1  high in HDR0, HDR1 and DATA.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, cpu_reset = 1, rx_ready = 0, loaded_words = 0, load_error = 0, busy = 0.
  - Memory contents are not cleared.
- Image format: 2-byte word count N (little-endian), then 4N bytes. Each word is little-endian, first byte = bits [7:0].
- States:
  - IDLE: rx_ready = 0. load_start → HDR0.
  - HDR0: rx_ready = 1. Transfer → len[7:0], go to HDR1.
  - HDR1: rx_ready = 1. Transfer → len[15:8], then:
    - len == 0 → RUN;
    - len > DEPTH → ERROR;
    - otherwise → DATA, with byte_cnt = 0 and word_idx = 0.
  - DATA: rx_ready = 1. On each transfer, rx_data goes into assembly byte lane byte_cnt and byte_cnt increments modulo 4. On the transfer with byte_cnt == 3:
    - mem[word_idx] <= {rx_data, asm[23:0]};
    - loaded_words <= word_idx + 1;
    - word_idx increments;
    - if word_idx + 1 == len → RUN.
  - RUN: cpu_reset = 0, rx_ready = 0. load_start → HDR0.
  - ERROR: cpu_reset = 1, load_error = 1, rx_ready = 0. load_start → HDR0 and clears load_error.
- Entering HDR0 from any state:
  - cpu_reset goes high on the same edge;
  - loaded_words <= 0;
  - load_error <= 0.
- Latency:
  - cpu_reset falls on the edge after the clock edge that accepts the final byte. The core then fetches pc = 0 with the full image visible.
  - Written words are readable the cycle after the write edge.
- instruction (combinational):
  - index = pc >> PC_SHIFT, truncated to 16 bits.
  - If cpu_reset == 1, or index ≥ loaded_words, or index ≥ DEPTH → NOP 32'h00000013.
  - Otherwise → mem[index]. pc low bits below PC_SHIFT are ignored.
- Simultaneous events:
  - load_start in the same cycle as a byte transfer: load_start wins, the byte is dropped, state = HDR0.
  - load_start during HDR0, HDR1 or DATA aborts the load and restarts at HDR0. Any partial word is discarded.
  - reset mid-load: returns to IDLE with cpu_reset = 1. Previously written memory words are unreachable because loaded_words = 0.
- Stalled input: rx_valid low in DATA holds all state indefinitely; there is no timeout.
- N == DEPTH: legal. The last write goes to mem[DEPTH-1]; word_idx is never used past that point.

Decomposition:
- Shared package `loader_pkg`:
  - state enum: IDLE, HDR0, HDR1, DATA, RUN, ERROR;
  - NOP_INSN = 32'h00000013;
  - byte-count width constant.
- Sub-module `instr_mem_array`: DEPTH×32, one synchronous write port (clk, we, waddr, wdata), one asynchronous read port. It replaces the inline instruction memory used by processor testbenches.

Test Plan:
- Basic load: reset 2 cycles; load_start; bytes 02 00 | B7 10 00 00 | 13 81 20 00 → mem[0] = 32'h000010B7, mem[1] = 32'h00208113. cpu_reset falls one cycle after the last byte; loaded_words = 2. pc = 0 → 000010B7, pc = 4 → 00208113, pc = 8 → 00000013.
- Zero length: bytes 00 00 → RUN immediately after the second byte; instruction = NOP for every pc; loaded_words = 0.
- Oversize: DEPTH = 256, header 01 01 (N = 257) → ERROR, load_error = 1, cpu_reset stays 1. A following load_start clears load_error; a valid 1-word load then reaches RUN.
- Backpressure/gaps: rx_valid toggled randomly across a 3-word image → same memory contents as the gap-free case. busy = 1 throughout; rx_ready = 0 after completion.
- Abort: load_start asserted after 6 data bytes of a 2-word image, concurrent with a valid byte → byte dropped, state HDR0, loaded_words = 0. A fresh 1-word image loads correctly.
- Reload and reset: in RUN, load_start → cpu_reset = 1 next edge; reset asserted mid-DATA → IDLE, cpu_reset = 1, instruction = NOP.
